arbiter_fsm: RTL and testbench
==============================

# arbiter_fsm

Two-requester grant arbiter. Requesters `req_0`/`req_1` compete for one shared resource. The block returns a registered, mutually exclusive grant that is held for as long as the winner keeps requesting, with an optional hold limit for fairness. It sits between two bus masters and the shared slave; its cycle behaviour is checked by the paired tester module.

## Interface
- `MAX_HOLD`, default 0: maximum consecutive grant cycles while the other side is requesting. 0 means unlimited. Legal range 0..255.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low reset. Sampled on the rising edge of `clock`; 0 resets the block.
- `req_0` in 1: request from requester 0. Level-sensitive; held high while the resource is wanted.
- `req_1` in 1: request from requester 1. Same rules as `req_0`.
- `gnt_0` out 1: grant to requester 0. Registered.
- `gnt_1` out 1: grant to requester 1. Registered.

## Operation
- The FSM has three states: IDLE, GNT0 and GNT1. `gnt_0` = (state==GNT0) and `gnt_1` = (state==GNT1), both driven from flops.
- **IDLE**:
  - If `req_0`, go to GNT0.
  - Else if `req_1`, go to GNT1.
  - Else stay in IDLE.
  - Exception: when the `favor_1` flag is set and `req_1` is high, go to GNT1 even if `req_0` is high.
- **GNT0**: stay while `req_0` is high and the hold limit has not expired. Otherwise go to IDLE.
- **GNT1**: symmetric to GNT0.
- **Default priority**: requester 0 wins simultaneous requests from IDLE.
- **Hold limit** (only when `MAX_HOLD` > 0):
  - The hold counter counts consecutive cycles in the current grant state.
  - It resets to 0 on every entry to IDLE.
  - When the counter reaches `MAX_HOLD` and the other requester is high, the holder is forced to IDLE.
  - The forced release sets `favor_1` (if GNT0 was preempted) or clears it (if GNT1 was preempted), so the preempted side loses the next IDLE decision.
  - `favor_1` has effect only on the first IDLE decision after a forced release and is cleared once that decision is taken.
- **No request**: the counter never forces a release when the other side is not requesting; the holder keeps the grant indefinitely.
- **Invariant**: `gnt_0` and `gnt_1` are never both high.
- **Illegal or unused state encodings** recover to IDLE on the next edge.

## Timing
- **Reset**: with `reset`==0 at a rising edge, after that edge the state is IDLE, `gnt_0`=0, `gnt_1`=0, counter=0 and `favor_1`=0. Requests are ignored while `reset` is 0.
- **Reset during a grant**: the grant drops on the first edge that samples `reset`==0.
- **Grant latency**: a request sampled high at edge k in IDLE asserts its grant immediately after edge k, i.e. one cycle of latency.
- **Release**: `req_x` sampled low at edge k in GNTx clears `gnt_x` after edge k.
- **Turnaround**: there is always one IDLE cycle between two grants, even when the other side is waiting. The earliest new grant appears after edge k+1.
- **Forced release**: with `MAX_HOLD`=N, a grant that started after edge k and faces a continuous competing request is high for exactly N cycles. The other grant rises one idle cycle later.
- **Simultaneous first requests** from IDLE: `gnt_0` only.

## Structure
- **Package `arbiter_fsm_pkg`**: state typedef (IDLE=2'b00, GNT0=2'b01, GNT1=2'b10) and the hold-counter width constant (8 bits).
- **Sub-module `arb_hold_timer`**:
  - Inputs: clear and enable.
  - Output: expired (count==`MAX_HOLD`).
  - Saturates rather than wrapping, and is disabled when `MAX_HOLD`==0.
- **Top level**: holds the FSM, the `favor_1` flag and the output flops.

## Test plan
- **Reset**: `reset`=0 for 2 cycles with `req_0`=`req_1`=1 → `gnt_0`=`gnt_1`=0. After `reset`=1, `gnt_0`=1 one edge later.
- **Single requester**:
  - `req_1` pulsed high for 4 cycles → `gnt_1` high for 4 cycles, lagging by 1; `gnt_0` stays 0.
  - `req_0` dropped mid-grant → `gnt_0` low after the next edge.
- **Contention, unlimited hold** (`MAX_HOLD`=0): both requests go high together → `gnt_0`=1. `req_0` drops after 5 cycles → one idle cycle, then `gnt_1`=1.
- **Hold limit** (`MAX_HOLD`=3), both requests held high continuously:
  - Grants alternate `gnt_0` ×3 cycles, idle ×1, `gnt_1` ×3 cycles, idle ×1, repeating.
  - The two grants are never overlapping.
- **Mid-grant reset**: in GNT1 assert `reset`=0 for 1 cycle → `gnt_1` low after that edge. Re-arbitration follows with `favor_1` cleared.
- **Mutual exclusion**: run 10k cycles of random requests → the bench checks `gnt_0`&`gnt_1`==0 every cycle.

Source files
------------

// File: rtl/arbiter_fsm_pkg.sv
// Shared types and constants for the two-requester grant arbiter.
// The state encoding is fixed; every other encoding recovers to IDLE.
package arbiter_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    localparam int HOLD_W = 8;

endpackage

// File: rtl/arb_hold_timer.sv
// Counts consecutive grant cycles and flags when the hold limit is reached.
// Saturates at MAX_HOLD. With MAX_HOLD == 0 the timer is inert and never expires.
module arb_hold_timer
    import arbiter_fsm_pkg::*;
#(
    parameter int MAX_HOLD = 0
) (
    input  logic clock,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [HOLD_W-1:0] LIMIT = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0] count;

    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (enable && (LIMIT != '0) && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (LIMIT != '0) && (count == LIMIT);

endmodule

// File: rtl/arbiter_fsm.sv
// Two-requester arbiter with registered, mutually exclusive grants and an
// optional hold limit that hands the resource over when the other side waits.
module arbiter_fsm
    import arbiter_fsm_pkg::*;
#(
    parameter int MAX_HOLD = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic req_0,
    input  logic req_1,
    output logic gnt_0,
    output logic gnt_1
);

    state_t state;
    logic   favor_1;
    logic   expired;
    logic   preempt;
    logic   stay_0;
    logic   stay_1;
    logic   hold_next;
    logic   timer_clear;

    // A holder is only preempted when its limit is up and the other side is waiting.
    assign preempt = req_0 & req_1 & expired;
    assign stay_0  = req_0 & ~preempt;
    assign stay_1  = req_1 & ~preempt;

    // hold_next is high exactly when the next state is a grant state, so the
    // timer's count equals the number of grant cycles already issued.
    always_comb begin
        hold_next = 1'b0;
        case (state)
            IDLE:    hold_next = req_0 | req_1;
            GNT0:    hold_next = stay_0;
            GNT1:    hold_next = stay_1;
            default: hold_next = 1'b0;
        endcase
    end

    assign timer_clear = ~hold_next | ~reset;

    arb_hold_timer #(
        .MAX_HOLD(MAX_HOLD)
    ) u_hold_timer (
        .clock  (clock),
        .clear  (timer_clear),
        .enable (hold_next),
        .expired(expired)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            gnt_0   <= 1'b0;
            gnt_1   <= 1'b0;
            favor_1 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_1 && (favor_1 || !req_0)) begin
                        state <= GNT1;
                        gnt_0 <= 1'b0;
                        gnt_1 <= 1'b1;
                    end else if (req_0) begin
                        state <= GNT0;
                        gnt_0 <= 1'b1;
                        gnt_1 <= 1'b0;
                    end else begin
                        state <= IDLE;
                        gnt_0 <= 1'b0;
                        gnt_1 <= 1'b0;
                    end
                    if (req_0 || req_1) begin
                        favor_1 <= 1'b0;
                    end
                end
                GNT0: begin
                    if (!stay_0) begin
                        state <= IDLE;
                        gnt_0 <= 1'b0;
                        gnt_1 <= 1'b0;
                        if (preempt) begin
                            favor_1 <= 1'b1;
                        end
                    end
                end
                GNT1: begin
                    if (!stay_1) begin
                        state <= IDLE;
                        gnt_0 <= 1'b0;
                        gnt_1 <= 1'b0;
                        if (preempt) begin
                            favor_1 <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_0 <= 1'b0;
                    gnt_1 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbiter_fsm.sv
// Scoreboard bench: two arbiters (unlimited hold and MAX_HOLD=3) share stimulus;
// each directed step queues the grants expected after the next rising edge.
module tb_arbiter_fsm;

    logic clock;
    logic reset;
    logic req_0;
    logic req_1;
    logic a_gnt_0, a_gnt_1;
    logic b_gnt_0, b_gnt_1;

    typedef struct {
        logic [1:0] ea;
        logic [1:0] eb;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   step_id = 0;
    bit   mutex_on = 0;

    arbiter_fsm #(.MAX_HOLD(0)) dut_a (
        .clock(clock), .reset(reset), .req_0(req_0), .req_1(req_1),
        .gnt_0(a_gnt_0), .gnt_1(a_gnt_1)
    );

    arbiter_fsm #(.MAX_HOLD(3)) dut_b (
        .clock(clock), .reset(reset), .req_0(req_0), .req_1(req_1),
        .gnt_0(b_gnt_0), .gnt_1(b_gnt_1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected values are {gnt_1, gnt_0} after the edge that samples these inputs.
    task automatic step(input logic rs, input logic r0, input logic r1,
                        input logic [1:0] ea, input logic [1:0] eb);
        @(negedge clock);
        reset = rs;
        req_0 = r0;
        req_1 = r1;
        step_id++;
        sb.push_back('{ea: ea, eb: eb, id: step_id});
    endtask

    // Monitor: samples one time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (mutex_on) begin
                tests++;
                if (((a_gnt_0 & a_gnt_1) !== 1'b0) || ((b_gnt_0 & b_gnt_1) !== 1'b0)) begin
                    fails++;
                    $display("FAIL mutex t=%0t a=%b%b b=%b%b required no double grant",
                             $time, a_gnt_1, a_gnt_0, b_gnt_1, b_gnt_0);
                end
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if ({a_gnt_1, a_gnt_0} !== e.ea) begin
                    fails++;
                    $display("FAIL hold0 step%0d got {gnt_1,gnt_0}=%b required %b",
                             e.id, {a_gnt_1, a_gnt_0}, e.ea);
                end
                tests++;
                if ({b_gnt_1, b_gnt_0} !== e.eb) begin
                    fails++;
                    $display("FAIL hold3 step%0d got {gnt_1,gnt_0}=%b required %b",
                             e.id, {b_gnt_1, b_gnt_0}, e.eb);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        req_0 = 1'b0;
        req_1 = 1'b0;
        mutex_on = 1'b1;

        // Reset holds grants low despite requests; req_0 wins on release.
        step(0, 1, 1, 2'b00, 2'b00);
        step(0, 1, 1, 2'b00, 2'b00);
        step(1, 1, 1, 2'b01, 2'b01);
        // Continuous contention: hold0 keeps gnt_0; hold3 alternates 3 on / 1 idle.
        step(1, 1, 1, 2'b01, 2'b01);
        step(1, 1, 1, 2'b01, 2'b01);
        step(1, 1, 1, 2'b01, 2'b00);
        step(1, 1, 1, 2'b01, 2'b10);
        step(1, 1, 1, 2'b01, 2'b10);
        step(1, 1, 1, 2'b01, 2'b10);
        step(1, 1, 1, 2'b01, 2'b00);
        step(1, 1, 1, 2'b01, 2'b01);
        step(1, 1, 1, 2'b01, 2'b01);
        step(1, 1, 1, 2'b01, 2'b01);
        step(1, 1, 1, 2'b01, 2'b00);
        // Reset while favor_1 is pending: it must be cleared, req_0 wins again.
        step(0, 1, 1, 2'b00, 2'b00);
        step(1, 1, 1, 2'b01, 2'b01);
        step(1, 0, 0, 2'b00, 2'b00);
        step(1, 0, 0, 2'b00, 2'b00);
        // req_1 alone for 4 cycles.
        for (int i = 0; i < 4; i++) step(1, 0, 1, 2'b10, 2'b10);
        step(1, 0, 0, 2'b00, 2'b00);
        step(1, 0, 0, 2'b00, 2'b00);
        // req_0 alone past the limit, then req_1 arrives: hold3 releases at once.
        for (int i = 0; i < 5; i++) step(1, 1, 0, 2'b01, 2'b01);
        step(1, 1, 1, 2'b01, 2'b00);
        step(1, 1, 1, 2'b01, 2'b10);
        // req_0 drops: one idle cycle, then gnt_1 on the unlimited arbiter.
        step(1, 0, 1, 2'b00, 2'b10);
        step(1, 0, 1, 2'b10, 2'b10);
        step(1, 0, 1, 2'b10, 2'b10);
        // Mid-grant reset in GNT1, then re-arbitration with default priority.
        step(0, 0, 1, 2'b00, 2'b00);
        step(1, 1, 1, 2'b01, 2'b01);
        step(1, 0, 1, 2'b00, 2'b00);
        step(1, 0, 1, 2'b10, 2'b10);
        step(1, 0, 0, 2'b00, 2'b00);
        step(1, 0, 0, 2'b00, 2'b00);

        // Random requests; the monitor checks mutual exclusion every cycle.
        for (int i = 0; i < 10000; i++) begin
            @(negedge clock);
            req_0 = 1'($urandom_range(0, 1));
            req_1 = 1'($urandom_range(0, 1));
        end

        @(negedge clock);
        @(negedge clock);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
